// File: rtl/gesture_pkg.sv
// Shared gesture definitions: event codes used by the queue and by every consumer of ev_code.
package gesture_pkg;

   typedef enum logic [1:0] {
      NONE = 2'b00,
      WEST = 2'b01,
      EAST = 2'b10,
      BOTH = 2'b11
   } gesture_code_t;

   function automatic gesture_code_t encode_gesture(input logic w, input logic e);
      gesture_code_t code;
      case ({w, e})
         2'b10:   code = WEST;
         2'b01:   code = EAST;
         2'b11:   code = BOTH;
         default: code = NONE;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/gesture_fifo.sv
// Synchronous FIFO for gesture events; callers must never push when full unless also popping.
module gesture_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   // NOTE: the storage array has no reset; entries are only observable through
   // rdata while count is non-zero, so stale contents can never leak out.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/gesture_event_queue.sv
// Gesture event queue: encodes West/East slide pulses, tags them with a sequence number and buffers them.
module gesture_event_queue
   import gesture_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int SEQ_W = 6
) (
   input  logic                       iCLK,
   input  logic                       iRST,
   input  logic                       Gest_W,
   input  logic                       Gest_E,
   output logic                       ev_valid,
   input  logic                       ev_ready,
   output logic [1:0]                 ev_code,
   output logic [SEQ_W-1:0]           ev_seq,
   output logic [$clog2(DEPTH):0]     ev_count,
   output logic                       overflow,
   input  logic                       ovf_clr
);

   localparam int EW = 2 + SEQ_W;

   gesture_code_t    in_code;
   logic             in_ev;
   logic             fifo_full;
   logic             fifo_empty;
   logic             do_push;
   logic             do_pop;
   logic             drop;
   logic [SEQ_W-1:0] seq_cnt;
   logic [EW-1:0]    head;

   assign in_code = encode_gesture(Gest_W, Gest_E);
   assign in_ev   = (in_code != NONE);

   // A full queue still accepts an event when the head leaves in the same cycle.
   assign do_pop  = ev_ready && !fifo_empty;
   assign do_push = in_ev && (!fifo_full || do_pop);
   assign drop    = in_ev && fifo_full && !do_pop;

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         seq_cnt  <= '0;
         overflow <= 1'b0;
      end else begin
         if (in_ev) seq_cnt <= seq_cnt + SEQ_W'(1);
         if (drop)         overflow <= 1'b1;
         else if (ovf_clr) overflow <= 1'b0;
      end
   end

   gesture_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
   ) u_fifo (
      .clk   (iCLK),
      .rst   (iRST),
      .push  (do_push),
      .pop   (do_pop),
      .wdata ({in_code, seq_cnt}),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (ev_count)
   );

   assign ev_valid = !fifo_empty;
   assign ev_code  = head[EW-1 -: 2];
   assign ev_seq   = head[SEQ_W-1:0];

endmodule

// File: tb/tb_gesture_event_queue.sv
// Randomized plus directed bench for gesture_event_queue against a queue-based reference model.
module tb_gesture_event_queue;

   localparam int DEPTH = 4;
   localparam int SEQ_W = 6;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic             iCLK = 1'b0;
   logic             iRST = 1'b1;
   logic             Gest_W = 1'b0;
   logic             Gest_E = 1'b0;
   logic             ev_ready = 1'b0;
   logic             ovf_clr = 1'b0;
   logic             ev_valid;
   logic [1:0]       ev_code;
   logic [SEQ_W-1:0] ev_seq;
   logic [CW-1:0]    ev_count;
   logic             overflow;

   gesture_event_queue #(
      .DEPTH (DEPTH),
      .SEQ_W (SEQ_W)
   ) dut (
      .iCLK     (iCLK),
      .iRST     (iRST),
      .Gest_W   (Gest_W),
      .Gest_E   (Gest_E),
      .ev_valid (ev_valid),
      .ev_ready (ev_ready),
      .ev_code  (ev_code),
      .ev_seq   (ev_seq),
      .ev_count (ev_count),
      .overflow (overflow),
      .ovf_clr  (ovf_clr)
   );

   always #10 iCLK = ~iCLK;

   typedef struct {
      int code;
      int seq;
   } ev_t;

   ev_t q[$];
   int  m_seq;
   bit  m_ovf;
   int  n_checks;
   int  n_fail;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic compare_outputs();
      check("ev_valid", 32'(ev_valid), (q.size() != 0) ? 32'd1 : 32'd0);
      check("ev_count", 32'(ev_count), 32'(q.size()));
      check("ev_code",  32'(ev_code),  (q.size() != 0) ? 32'(q[0].code) : 32'd0);
      check("ev_seq",   32'(ev_seq),   (q.size() != 0) ? 32'(q[0].seq)  : 32'd0);
      check("overflow", 32'(overflow), 32'(m_ovf));
   endtask

   // Reference behaviour for one clock edge given the inputs sampled there.
   task automatic model_edge(input bit w, input bit e, input bit rdy, input bit clr, input bit rs);
      int  code;
      bit  popped;
      bit  dropped;
      ev_t ev;
      if (rs) begin
         q.delete();
         m_seq = 0;
         m_ovf = 1'b0;
         return;
      end
      code    = (w ? 1 : 0) + (e ? 2 : 0);
      popped  = rdy && (q.size() > 0);
      dropped = (code != 0) && (q.size() == DEPTH) && !popped;
      if (popped) void'(q.pop_front());
      if (code != 0) begin
         if (!dropped) begin
            ev.code = code;
            ev.seq  = m_seq;
            q.push_back(ev);
         end
         m_seq = (m_seq + 1) % (1 << SEQ_W);
      end
      if (dropped)  m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
   endtask

   // Called at a negedge: check current outputs, apply inputs, advance one clock.
   task automatic cycle(input bit w, input bit e, input bit rdy, input bit clr, input bit rs);
      compare_outputs();
      Gest_W   = w;
      Gest_E   = e;
      ev_ready = rdy;
      ovf_clr  = clr;
      iRST     = rs;
      @(posedge iCLK);
      model_edge(w, e, rdy, clr, rs);
      @(negedge iCLK);
      Gest_W  = 1'b0;
      Gest_E  = 1'b0;
      ovf_clr = 1'b0;
      iRST    = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      iRST     = 1'b1;
      @(posedge iCLK);
      model_edge(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge iCLK);
      iRST = 1'b0;
      check("reset_valid", 32'(ev_valid), 32'd0);
      check("reset_count", 32'(ev_count), 32'd0);

      // Single West event consumed immediately.
      for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      check("w_valid_n1", 32'(ev_valid), 32'd1);
      check("w_code_n1",  32'(ev_code),  32'd1);
      check("w_seq_n1",   32'(ev_seq),   32'd0);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check("w_count_n2", 32'(ev_count), 32'd0);

      // Both slides in one cycle form a single BOTH entry.
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      check("both_count", 32'(ev_count), 32'd1);
      check("both_code",  32'(ev_code),  32'd3);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      // Overflow: five East events with no consumer, drain, then check the seq gap.
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("ovf_count", 32'(ev_count), 32'd4);
      check("ovf_flag",  32'(overflow), 32'd1);
      for (int i = 0; i < 4; i++) begin
         check("drain_seq", 32'(ev_seq), 32'(i));
         cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check("gap_seq", 32'(ev_seq), 32'd5);

      // Full queue with simultaneous push and pop: no drop.
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("full_count", 32'(ev_count), 32'd4);
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      check("pp_count", 32'(ev_count), 32'd4);
      check("pp_ovf",   32'(overflow), 32'd0);

      // Sequence wrap with a consumer always ready.
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 70; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      check("wrap_ovf", 32'(overflow), 32'd0);
      check("wrap_seq", 32'(ev_seq),   32'd5);

      // Clear coinciding with a drop keeps the flag, plain clear drops it.
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      check("clr_drop_ovf", 32'(overflow), 32'd1);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("clr_ovf", 32'(overflow), 32'd0);

      // Reset mid-operation discards entries and ignores a coincident pulse.
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      check("rst_valid", 32'(ev_valid), 32'd0);
      check("rst_count", 32'(ev_count), 32'd0);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("rst_seq", 32'(ev_seq), 32'd0);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         cycle(($urandom_range(99) < 35), ($urandom_range(99) < 35),
               ($urandom_range(99) < 45), ($urandom_range(99) < 8),
               ($urandom_range(299) == 0));
      end
      compare_outputs();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/gesture_event_queue.md
GESTURE_EVENT_QUEUE -- requirements
Module: gesture_event_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queued gesture events (power of 2, 2..16).
REQ-002 SHALL have parameter SEQ_W, default 6, width of the event sequence number.
REQ-003 SHALL have port iCLK  input  1  system clock (50 MHz).
REQ-004 SHALL have port iRST  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port Gest_W  input  1  one-cycle pulse, West slide detected.
REQ-006 SHALL have port Gest_E  input  1  one-cycle pulse, East slide detected.
REQ-007 SHALL have port ev_valid  output  1  head event available.
REQ-008 SHALL have port ev_ready  input  1  consumer accepts head event.
REQ-009 SHALL have port ev_code  output  2  head event code.
REQ-010 SHALL have port ev_seq  output  SEQ_W  head event sequence number.
REQ-011 SHALL have port ev_count  output  $clog2(DEPTH)+1  occupancy.
REQ-012 SHALL have port overflow  output  1  sticky flag, an event was dropped.
REQ-013 SHALL have port ovf_clr  input  1  clears overflow.

Function
REQ-014 SHALL form an input event when Gest_W or Gest_E is high: code WEST=2'b01 (W only), EAST=2'b10 (E only), BOTH=2'b11 (same cycle); 2'b00 never enqueued.
REQ-015 SHALL push the event, tagged with the current sequence counter, on the cycle it arrives; the sequence counter then increments modulo 2^SEQ_W (63 -> 0 at default).
REQ-016 SHALL increment the sequence counter for dropped events too, so gaps in ev_seq expose losses.
REQ-017 SHALL assert ev_valid exactly when ev_count != 0; ev_code/ev_seq SHALL show the oldest entry and be 0 when empty.
REQ-018 SHALL pop the head on a cycle where ev_valid && ev_ready; ev_ready while empty has no effect.
REQ-019 SHALL have latency 1: an event pushed in cycle N is visible on ev_valid in cycle N+1; no combinational bypass from Gest_* to outputs.
REQ-020 SHALL, on simultaneous push and pop when non-empty (including full), perform both; ev_count unchanged.
REQ-021 SHALL, on push when full without a pop that cycle, drop the new event, keep contents, and set overflow in cycle N+1.
REQ-022 SHALL clear overflow on ovf_clr; if ovf_clr coincides with a new drop, overflow SHALL stay set.
REQ-023 SHALL keep pointers wrapping modulo DEPTH; ev_count SHALL range 0..DEPTH.

Reset
REQ-024 SHALL on iRST force ev_valid=0, ev_code=0, ev_seq=0, ev_count=0, overflow=0, sequence counter=0, pointers=0.
REQ-025 SHALL discard all queued events on iRST asserted mid-operation; Gest_* pulses during iRST are ignored.
REQ-026 SHALL need no storage-array reset; stale contents SHALL never be visible because ev_valid=0.

Structure
REQ-027 SHALL take the gesture code enum (NONE, WEST, EAST, BOTH) from shared package gesture_pkg, also used by consumers of ev_code.
REQ-028 SHALL implement storage as one sub-module gesture_fifo (synchronous, DEPTH x (2+SEQ_W), push/pop/full/empty/count); event encoding, sequence counter and overflow logic stay in the top.

Verification
REQ-029 Reset, then Gest_W pulse at cycle 10, ev_ready=1 -> ev_valid=1 at cycle 11 only, ev_code=01, ev_seq=0, ev_count back to 0 at cycle 12.
REQ-030 Gest_W and Gest_E high in the same cycle -> exactly one entry, ev_code=11.
REQ-031 ev_ready=0, five Gest_E pulses -> ev_count=4, overflow=1 after the fifth; draining yields ev_seq 0,1,2,3; next event gets ev_seq=5.
REQ-032 Full queue, Gest_W coincident with ev_ready=1 -> no drop, ev_count stays 4, overflow stays 0, new tail ev_seq correct.
REQ-033 70 events with ev_ready=1 -> ev_seq wraps 63 -> 0, no overflow; ovf_clr coincident with a drop -> overflow stays 1.
REQ-034 iRST asserted with 3 queued events -> ev_valid=0, ev_count=0 next cycle; next event after reset has ev_seq=0.
